// File: rtl/seen_event_logger_pkg.sv
// Shared defaults and types for the seen-event logger slice.
// Timestamp, FIFO depth and statistics widths used when the top is not overridden.
package seen_logger_pkg;
    localparam int DEF_TS_W  = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef logic [DEF_TS_W-1:0] ts_t;
endpackage

// File: rtl/seen_event_logger_if.sv
// Event drain channel from the logger (master) to the host/debug consumer (slave).
interface seen_event_logger_if #(
    parameter int TS_W = 16
) ();
    // Transfer happens on a rising edge where evt_valid & evt_ready are both high;
    // while evt_valid=1 and evt_ready=0 the master holds evt_valid and evt_ts stable,
    // and evt_valid never depends combinationally on evt_ready.
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;

    modport master (output evt_valid, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_ts, output evt_ready);
endinterface

// File: rtl/seen_event_logger_evt_fifo.sv
// Generic first-word-fall-through synchronous FIFO; head entry is visible on rd_data
// whenever empty=0. Push and pop may coincide when full (new entry lands at the tail).
module evt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // When full, wr_ptr equals rd_ptr: a simultaneous push overwrites the slot being popped.
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only observed while level is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
endmodule

// File: rtl/seen_event_logger.sv
// Timestamps each 'seen' pulse with a free-running cycle counter, buffers the stamps
// in a FWFT FIFO drained over ready/valid, and keeps clearable saturating statistics.
module seen_event_logger
    import seen_logger_pkg::*;
#(
    parameter int TS_W  = DEF_TS_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    seen,
    input  logic                    clr_stats,
    seen_event_logger_if.master     evt,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [CNT_W-1:0]        match_count,
    output logic [CNT_W-1:0]        drop_count,
    output logic                    overflow
);
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             overflow_q, overflow_d;

    logic full, empty, push, pop, drop;
    logic [TS_W-1:0] head_ts;

    // pop uses FIFO state rather than evt_valid so valid stays a pure state output.
    assign pop  = !empty & evt.evt_ready;
    assign push = seen & (!full | pop);
    assign drop = seen & full & !pop;

    evt_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push    (push),
        .wr_data (ts_q),
        .pop     (pop),
        .rd_data (head_ts),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_comb begin
        ts_d = ts_q + TS_W'(1);

        // Clear acts first, then this cycle's events are counted on top of zero.
        match_d    = clr_stats ? '0 : match_q;
        drop_d     = clr_stats ? '0 : drop_q;
        overflow_d = clr_stats ? 1'b0 : overflow_q;

        if (seen && (match_d != '1)) begin
            match_d = match_d + CNT_W'(1);
        end
        if (drop && (drop_d != '1)) begin
            drop_d = drop_d + CNT_W'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_q       <= '0;
            match_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            match_q    <= match_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt.evt_valid = !empty;
    assign evt.evt_ts    = head_ts;
    assign match_count   = match_q;
    assign drop_count    = drop_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_seen_event_logger.sv
// Directed bench for seen_event_logger: a default instance (TS_W=16, DEPTH=4, CNT_W=8)
// and a narrow instance (TS_W=4, CNT_W=2) for timestamp wrap and counter saturation.
module tb_seen_event_logger;
    logic clk;
    logic resetn;
    logic seen_a, clr_a;
    logic seen_b, clr_b;
    logic [2:0] level_a, level_b;
    logic [7:0] match_a, drop_a;
    logic [1:0] match_b, drop_b;
    logic       ovf_a, ovf_b;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    int handshakes;

    seen_event_logger_if #(.TS_W(16)) a_if ();
    seen_event_logger_if #(.TS_W(4))  b_if ();

    seen_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut_a (
        .clk         (clk),
        .resetn      (resetn),
        .seen        (seen_a),
        .clr_stats   (clr_a),
        .evt         (a_if),
        .fifo_level  (level_a),
        .match_count (match_a),
        .drop_count  (drop_a),
        .overflow    (ovf_a)
    );

    seen_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut_b (
        .clk         (clk),
        .resetn      (resetn),
        .seen        (seen_b),
        .clr_stats   (clr_b),
        .evt         (b_if),
        .fifo_level  (level_b),
        .match_count (match_b),
        .drop_count  (drop_b),
        .overflow    (ovf_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        seen_a = 1'b0; clr_a = 1'b0; a_if.evt_ready = 1'b0;
        seen_b = 1'b0; clr_b = 1'b0; b_if.evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;  // current cycle holds ts=0
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic seen;
        logic ready;
        logic clr;
        logic exp_valid;
        int   exp_ts;
        int   exp_level;
        int   exp_match;
        int   exp_drop;
        int   exp_ovf;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // fill, drop, full pop+push, clear-with-drop, clear-alone, drain, idle ready on empty
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 2, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 3, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 4, 4, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 4, 5, 1, 1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 4, 6, 1, 1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 4, 1, 1, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 4, 0, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 3, 0, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 2, 0, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 1, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};

        // reset state
        reset_dut();
        check("rst_valid", int'(a_if.evt_valid), 0);
        check("rst_level", int'(level_a), 0);
        check("rst_match", int'(match_a), 0);
        check("rst_drop",  int'(drop_a), 0);
        check("rst_ovf",   int'(ovf_a), 0);

        // seen at cycles 3 and 7 with ready held high; scoreboard on handshakes
        handshakes = 0;
        for (int c = 0; c < 10; c++) begin
            seen_a = (c == 3 || c == 7);
            a_if.evt_ready = 1'b1;
            if (seen_a) exp_q.push_back(16'(c));
            if (a_if.evt_valid && a_if.evt_ready) begin
                handshakes++;
                if (exp_q.size() == 0) check("t1_unexpected_pop", 1, 0);
                else check($sformatf("t1_ts_c%0d", c), int'(a_if.evt_ts), int'(exp_q.pop_front()));
            end
            step();
        end
        seen_a = 1'b0;
        check("t1_handshakes", handshakes, 2);
        check("t1_left", exp_q.size(), 0);
        check("t1_level", int'(level_a), 0);
        check("t1_match", int'(match_a), 2);

        // table: fill/drop, full pop+push, clr with drop, clr alone, drain
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            seen_a = vecs[i].seen;
            a_if.evt_ready = vecs[i].ready;
            clr_a = vecs[i].clr;
            step();
            check($sformatf("v%0d_valid", i), int'(a_if.evt_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("v%0d_ts", i), int'(a_if.evt_ts), vecs[i].exp_ts);
            check($sformatf("v%0d_level", i), int'(level_a), vecs[i].exp_level);
            check($sformatf("v%0d_match", i), int'(match_a), vecs[i].exp_match);
            check($sformatf("v%0d_drop", i),  int'(drop_a),  vecs[i].exp_drop);
            check($sformatf("v%0d_ovf", i),   int'(ovf_a),   vecs[i].exp_ovf);
        end
        seen_a = 1'b0; clr_a = 1'b0; a_if.evt_ready = 1'b0;

        // narrow instance: timestamp wrap 15 -> 0, counter saturation at 3
        reset_dut();
        for (int c = 0; c < 15; c++) step();
        seen_b = 1'b1;
        step();
        check("t5_ts15", int'(b_if.evt_ts), 15);
        check("t5_lvl1", int'(level_b), 1);
        step();
        check("t5_head15", int'(b_if.evt_ts), 15);
        check("t5_lvl2", int'(level_b), 2);
        check("t5_match2", int'(match_b), 2);
        seen_b = 1'b0;
        b_if.evt_ready = 1'b1;
        step();
        check("t5_wrap0", int'(b_if.evt_ts), 0);
        check("t5_lvl_after_pop", int'(level_b), 1);
        b_if.evt_ready = 1'b0;
        seen_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t5_match_sat%0d", k), int'(match_b), 3);
            check($sformatf("t5_lvl_fill%0d", k), int'(level_b), 2 + k);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t5_drop%0d", k), int'(drop_b), (k < 3) ? k + 1 : 3);
        end
        seen_b = 1'b0;
        check("t5_ovf", int'(ovf_b), 1);
        check("t5_match_final", int'(match_b), 3);
        check("t5_head_kept", int'(b_if.evt_ts), 0);

        // asynchronous reset with three entries buffered
        reset_dut();
        seen_a = 1'b1;
        repeat (3) step();
        seen_a = 1'b0;
        check("t6_pre_level", int'(level_a), 3);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_valid", int'(a_if.evt_valid), 0);
        check("t6_rst_level", int'(level_a), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        seen_a = 1'b1;
        step();
        seen_a = 1'b0;
        check("t6_post_valid", int'(a_if.evt_valid), 1);
        check("t6_post_ts", int'(a_if.evt_ts), 0);
        check("t6_post_level", int'(level_a), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
